// File: rtl/alu_seq_ctrl.sv
// Multi-cycle ALU sequencer: decodes a data-processing request, launches it and times its completion.
// Define ALU_SEQ_CTRL_DIV_EN to enable SDIV/UDIV decode; otherwise those functions decode as illegal.
module alu_seq_ctrl #(
  parameter int unsigned MLA_LAT = 2,
  parameter int unsigned DIV_LAT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       instr_valid,
  input  logic [3:0] Op,
  input  logic [3:0] Funct,
  output logic       instr_ready,
  output logic [2:0] ALUControl,
  output logic       MLA_Select,
  output logic       alu_start,
  output logic       busy,
  output logic       result_valid,
  output logic       illegal
);

  localparam int unsigned CNT_W = 8;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [CNT_W-1:0] MLA_CNT = CNT_W'(MLA_LAT - 1);
`ifdef ALU_SEQ_CTRL_DIV_EN
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);
`else
  logic unused_div_lat;
  assign unused_div_lat = ^CNT_W'(DIV_LAT);
`endif

  logic [0:0]       state, next_state;
  logic [CNT_W-1:0] count, next_count;
  logic             accept;
  logic             ill_q;
  logic [2:0]       dec_ctl;
  logic             dec_mla, dec_ill;
  logic [CNT_W-1:0] dec_cnt;

  // Handshake and status are derived from the registered state and gated by reset.
  always_comb begin
    instr_ready  = !reset && ((state == IDLE) || (count == '0));
    busy         = !reset && (state == RUN) && (count != '0);
    result_valid = !reset && (state == RUN) && (count == '0);
    illegal      = result_valid && ill_q;
    accept       = instr_valid && instr_ready;
  end

  // Instruction decode; dec_cnt holds latency minus one.
  always_comb begin
    dec_ctl = 3'b000;
    dec_mla = 1'b0;
    dec_ill = 1'b0;
    dec_cnt = '0;
    if (Op == 4'b0000) begin
      case (Funct)
        4'b0100: dec_ctl = 3'b000;
        4'b0010: dec_ctl = 3'b001;
        4'b0000: dec_ctl = 3'b010;
        4'b1100: dec_ctl = 3'b011;
        4'b1010: begin
          dec_ctl = 3'b100;
          dec_mla = 1'b1;
          dec_cnt = MLA_CNT;
        end
`ifdef ALU_SEQ_CTRL_DIV_EN
        4'b1000: begin
          dec_ctl = 3'b101;
          dec_cnt = DIV_CNT;
        end
        4'b1001: begin
          dec_ctl = 3'b110;
          dec_cnt = DIV_CNT;
        end
`endif
        default: dec_ill = 1'b1;
      endcase
    end
  end

  // Next-state and countdown logic.
  always_comb begin
    next_state = state;
    next_count = count;
    if (accept) begin
      next_state = RUN;
      next_count = dec_cnt;
    end else if (state == RUN) begin
      if (count != '0) next_count = count - CNT_W'(1);
      else             next_state = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      ALUControl <= 3'b000;
      MLA_Select <= 1'b0;
      ill_q      <= 1'b0;
      alu_start  <= 1'b0;
    end else begin
      state     <= next_state;
      count     <= next_count;
      alu_start <= accept;
      if (accept) begin
        ALUControl <= dec_ctl;
        MLA_Select <= dec_mla;
        ill_q      <= dec_ill;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed scoreboard bench for alu_seq_ctrl with MLA_LAT=3, DIV_LAT=16.
module tb_alu_seq_ctrl;

  localparam int unsigned MLA_LAT = 3;
  localparam int unsigned DIV_LAT = 16;

  logic       clk;
  logic       reset;
  logic       instr_valid;
  logic [3:0] Op;
  logic [3:0] Funct;
  logic       instr_ready;
  logic [2:0] ALUControl;
  logic       MLA_Select;
  logic       alu_start;
  logic       busy;
  logic       result_valid;
  logic       illegal;

  alu_seq_ctrl #(.MLA_LAT(MLA_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .Op(Op), .Funct(Funct),
    .instr_ready(instr_ready), .ALUControl(ALUControl), .MLA_Select(MLA_Select),
    .alu_start(alu_start), .busy(busy), .result_valid(result_valid), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [2:0] ctl;
    logic       ill;
  } exp_t;

  exp_t rq[$];
  int   sq[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   last_lat;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  // Reference decode derived from the instruction table.
  function automatic void model(input logic [3:0] op, input logic [3:0] f,
                                output logic [2:0] ctl, output logic mla,
                                output logic ill, output int lat);
    ctl = 3'b000; mla = 1'b0; ill = 1'b0; lat = 1;
    if (op == 4'b0000) begin
      case (f)
        4'b0100: ctl = 3'b000;
        4'b0010: ctl = 3'b001;
        4'b0000: ctl = 3'b010;
        4'b1100: ctl = 3'b011;
        4'b1010: begin ctl = 3'b100; mla = 1'b1; lat = int'(MLA_LAT); end
`ifdef ALU_SEQ_CTRL_DIV_EN
        4'b1000: begin ctl = 3'b101; lat = int'(DIV_LAT); end
        4'b1001: begin ctl = 3'b110; lat = int'(DIV_LAT); end
`endif
        default: ill = 1'b1;
      endcase
    end
  endfunction

  // Advance one clock, then compare launch/completion pulses against the scoreboard.
  task automatic tick();
    logic exp_rv, exp_st;
    @(posedge clk);
    #2;
    cyc++;
    exp_rv = (rq.size() > 0) && (rq[0].cyc == cyc);
    chk("result_valid", 8'(result_valid), 8'(exp_rv));
    if (exp_rv) begin
      chk("illegal", 8'(illegal), 8'(rq[0].ill));
      chk("alu_ctrl_at_result", 8'(ALUControl), 8'(rq[0].ctl));
      void'(rq.pop_front());
    end else begin
      chk("illegal_quiet", 8'(illegal), 8'(0));
    end
    exp_st = (sq.size() > 0) && (sq[0] == cyc);
    chk("alu_start", 8'(alu_start), 8'(exp_st));
    if (exp_st) void'(sq.pop_front());
  endtask

  task automatic issue(input logic [3:0] op, input logic [3:0] f);
    logic [2:0] ctl;
    logic mla, ill;
    int lat;
    model(op, f, ctl, mla, ill, lat);
    last_lat = lat;
    chk("instr_ready_at_issue", 8'(instr_ready), 8'(1));
    instr_valid = 1'b1;
    Op = op;
    Funct = f;
    rq.push_back('{cyc + lat, ctl, ill});
    sq.push_back(cyc + 1);
    tick();
    instr_valid = 1'b0;
    chk("alu_ctrl_after_accept", 8'(ALUControl), 8'(ctl));
    chk("mla_select_after_accept", 8'(MLA_Select), 8'(mla));
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (rq.size() > 0 || sq.size() > 0); i++) tick();
    chk("drain_timeout", 8'(rq.size() + sq.size()), 8'(0));
  endtask

  initial begin
    reset = 1'b1;
    instr_valid = 1'b1;
    Op = 4'b0000;
    Funct = 4'b0100;

    // Reset with a pending request: nothing accepted, all outputs low.
    repeat (3) tick();
    chk("rst_alu_ctrl", 8'(ALUControl), 8'(0));
    chk("rst_mla_select", 8'(MLA_Select), 8'(0));
    chk("rst_busy", 8'(busy), 8'(0));
    chk("rst_instr_ready", 8'(instr_ready), 8'(0));
    chk("rst_illegal", 8'(illegal), 8'(0));
    reset = 1'b0;
    instr_valid = 1'b0;
    #1;
    chk("ready_after_release", 8'(instr_ready), 8'(1));
    tick();

    // ADD, SUB, AND, ORR back-to-back.
    issue(4'b0000, 4'b0100);
    issue(4'b0000, 4'b0010);
    issue(4'b0000, 4'b0000);
    issue(4'b0000, 4'b1100);
    drain();

    // MLA with three-cycle latency, then ADD clears the accumulate select.
    issue(4'b0000, 4'b1010);
    chk("mla_ready_t1", 8'(instr_ready), 8'(0));
    chk("mla_busy_t1", 8'(busy), 8'(1));
    tick();
    chk("mla_ready_t2", 8'(instr_ready), 8'(0));
    tick();
    chk("mla_ready_t3", 8'(instr_ready), 8'(1));
    chk("mla_busy_t3", 8'(busy), 8'(0));
    issue(4'b0000, 4'b0100);
    drain();

    // UDIV: long latency when divide is enabled, single-cycle illegal otherwise.
    issue(4'b0000, 4'b1001);
    for (int k = 1; k < last_lat; k++) begin
      chk("udiv_busy", 8'(busy), 8'(1));
      chk("udiv_ready", 8'(instr_ready), 8'(0));
      tick();
    end
    chk("udiv_busy_done", 8'(busy), 8'(0));
    chk("udiv_ready_done", 8'(instr_ready), 8'(1));
    drain();

    // Undefined function and non-data-processing class.
    issue(4'b0000, 4'b1111);
    issue(4'b0100, 4'b0000);
    issue(4'b0000, 4'b0011);
    drain();

    // SDIV aborted by reset mid-flight.
    issue(4'b0000, 4'b1000);
    repeat (4) tick();
    reset = 1'b1;
    instr_valid = 1'b1;
    Op = 4'b0000;
    Funct = 4'b0010;
    #1;
    chk("abort_result_valid", 8'(result_valid), 8'(0));
    chk("abort_ready", 8'(instr_ready), 8'(0));
    chk("abort_busy", 8'(busy), 8'(0));
    rq.delete();
    sq.delete();
    tick();
    reset = 1'b0;
    instr_valid = 1'b0;
    repeat (20) tick();
    issue(4'b0000, 4'b0010);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 Parameters (name, default, meaning): the block SHALL provide the following.
- MLA_LAT, 2: MLA latency in cycles, legal range 1..255.
- DIV_LAT, 16: SDIV/UDIV latency in cycles, legal range 1..255.
REQ-002 Ports (name, direction, width, meaning): the block SHALL provide the following, in this order.
- clk, in, 1: single clock, rising edge.
- reset, in, 1: synchronous, active-high reset.
- instr_valid, in, 1: decode request present.
- Op, in, 4: instruction class.
- Funct, in, 4: data-processing function.
- instr_ready, out, 1: block can accept a request.
- ALUControl, out, 3: registered ALU operation select.
- MLA_Select, out, 1: registered accumulate-path select.
- alu_start, out, 1: one-cycle launch pulse to the datapath.
- busy, out, 1: an operation is in flight.
- result_valid, out, 1: one-cycle completion pulse.
- illegal, out, 1: undefined data-processing Funct; qualified by result_valid.
REQ-003 There SHALL be one clock only; reset SHALL be synchronous and active-high.

Function
REQ-004 Acceptance SHALL occur on a rising edge where instr_valid && instr_ready; instr_valid SHALL be ignored otherwise.
REQ-005 Decode at acceptance, with Op=0000, SHALL be as follows.
- Funct 0100: ADD, ALUControl=000, L=1.
- Funct 0010: SUB, ALUControl=001, L=1.
- Funct 0000: AND, ALUControl=010, L=1.
- Funct 1100: ORR, ALUControl=011, L=1.
- Funct 1010: MLA, ALUControl=100, L=MLA_LAT.
- Funct 1000: SDIV, ALUControl=101, L=DIV_LAT.
- Funct 1001: UDIV, ALUControl=110, L=DIV_LAT.
REQ-006 Op=0000 with any other Funct SHALL decode to ALUControl=000, L=1, illegal=1.
REQ-007 Op≠0000 SHALL decode to ALUControl=000, L=1, illegal=0.
REQ-008 MLA_Select SHALL be 1 only for MLA and 0 for every other accepted decode; no value SHALL be held over from a previous instruction.
REQ-009 The FSM SHALL have two states: IDLE and RUN.
- IDLE to RUN on acceptance.
- RUN to IDLE when the countdown reaches 0 with no new acceptance.
- RUN to RUN on a back-to-back acceptance.
REQ-010 On acceptance at edge T, the 8-bit countdown SHALL load L-1.
- It SHALL decrement each cycle in RUN while nonzero.
REQ-011 ALUControl and MLA_Select SHALL update at edge T and hold until the next acceptance.
REQ-012 alu_start SHALL be high for exactly the cycle following edge T.
REQ-013 result_valid SHALL be high for exactly one cycle, that cycle being T+L.
- illegal SHALL be valid in that same cycle and SHALL be 0 whenever result_valid=0.
REQ-014 instr_ready SHALL equal (state==IDLE) || (state==RUN && count==0).
- This allows back-to-back issue with zero bubble, including L=1.
REQ-015 busy SHALL equal (state==RUN && count≠0).
REQ-016 On a back-to-back acceptance in a cycle where result_valid=1, the new alu_start SHALL follow in the next cycle, and both pulses SHALL remain distinct.

Reset
REQ-017 While reset=1 the outputs SHALL take these values.
- state=IDLE, count=0.
- ALUControl=000, MLA_Select=0.
- alu_start=0, result_valid=0, illegal=0, busy=0.
- instr_ready=0 during reset, 1 in the first cycle after release.
REQ-018 A reset asserted mid-operation SHALL abort the operation with no result_valid pulse.
- A request presented in the cycle reset is asserted SHALL NOT be accepted.

Configuration
REQ-019 The macro ALU_SEQ_CTRL_DIV_EN SHALL select divide support.
- Defined: SDIV/UDIV SHALL decode per REQ-005.
- Undefined: Funct 1000/1001 SHALL decode as illegal per REQ-006, and DIV_LAT SHALL be unused.

Verification
REQ-020 Reset with instr_valid=1: all outputs SHALL be zero during reset; instr_ready=1 in the first cycle after release; nothing SHALL be accepted during reset.
REQ-021 ADD, SUB, AND, ORR issued back-to-back: four alu_start pulses and four consecutive result_valid pulses; ALUControl sequence 000, 001, 010, 011; instr_ready held at 1.
REQ-022 MLA with MLA_LAT=3, accepted at T: ALUControl=100 and MLA_Select=1 from T+1; result_valid at T+3; instr_ready=0 at T+1 and T+2; then ADD leaves MLA_Select=0.
REQ-023 UDIV with DIV_LAT=16 and the macro defined: result_valid at T+16, busy high T+1 to T+15; with the macro undefined, illegal=1 and result_valid at T+1.
REQ-024 Op=0000, Funct=1111: ALUControl=000, illegal=1 with result_valid at T+1; Op=0100: ALUControl=000, illegal=0.
REQ-025 SDIV accepted, reset asserted at T+5: no result_valid pulse; next request after release completes normally.
